// File: rtl/decode.sv
// RV32I decode stage: instruction decode, 32x32 register file with write-first bypass,
// load-use hazard detection and the decode/execute pipeline register.
module decode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [63:0]     fetch_dec_reg,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_pc_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic [2:0]      ex_funct3,
    output logic [2:0]      ex_branch_type
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            pc_src;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic [2:0]      funct3;
        logic [2:0]      branch_type;
    } ex_t;

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [4:0]      rs1, rs2, rd;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            use_rs1, use_rs2, legal, load_use;
    ex_t             dec, ex_d, ex_q;
    logic [XLEN-1:0] rf_d [32];
    logic [XLEN-1:0] rf_q [32];

    assign inst   = fetch_dec_reg[63:32];
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Write-first read ports: a same-cycle write-back is visible to the instruction in decode.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) begin
            rs1_val = (wb_en && wb_rd == rs1) ? wb_data : rf_q[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_val = (wb_en && wb_rd == rs2) ? wb_data : rf_q[rs2];
        end
    end

    always_comb begin
        dec          = '0;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        legal        = 1'b1;
        dec.pc       = fetch_dec_reg[31:0];
        dec.rs1_data = rs1_val;
        dec.rs2_data = rs2_val;
        dec.alu_op   = ALU_ADD;
        case (opcode)
            OP_R: begin
                dec.alu_op    = alu_from_f3(f3, inst[30]);
                dec.reg_write = 1'b1;
                dec.rd        = rd;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_IMM: begin
                dec.alu_op    = alu_from_f3(f3, inst[30] && f3 == 3'b101);
                dec.alu_src   = 1'b1;
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
                dec.rd        = rd;
                use_rs1       = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_src   = 1'b1;
                dec.imm       = imm_i;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = rd;
                dec.funct3    = f3;
                use_rs1       = 1'b1;
            end
            OP_STORE: begin
                dec.alu_src   = 1'b1;
                dec.imm       = imm_s;
                dec.mem_write = 1'b1;
                dec.funct3    = f3;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm = imm_b;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case (f3)
                    3'b000:  dec.branch_type = 3'd1;
                    3'b001:  dec.branch_type = 3'd2;
                    3'b100:  dec.branch_type = 3'd3;
                    3'b101:  dec.branch_type = 3'd4;
                    3'b110:  dec.branch_type = 3'd5;
                    3'b111:  dec.branch_type = 3'd6;
                    default: legal = 1'b0;
                endcase
            end
            OP_LUI: begin
                dec.alu_op    = ALU_PASSB;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
                dec.rd        = rd;
            end
            OP_AUIPC: begin
                dec.alu_src   = 1'b1;
                dec.pc_src    = 1'b1;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
                dec.rd        = rd;
            end
            OP_JAL, OP_JALR: begin
                dec.alu_src     = 1'b1;
                dec.pc_src      = 1'b1;
                dec.imm         = (opcode == OP_JAL) ? imm_j : imm_i;
                dec.reg_write   = 1'b1;
                dec.rd          = rd;
                dec.branch_type = 3'd7;
                use_rs1         = (opcode == OP_JALR);
            end
            default: legal = 1'b0;
        endcase
        dec.valid = legal;
        if (!legal) begin
            dec     = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                      ((use_rs1 && rs1 == ex_q.rd) || (use_rs2 && rs2 == ex_q.rd));
    assign stall    = load_use && !flush;

    always_comb begin
        ex_d = (flush || load_use) ? '0 : dec;
        rf_d = rf_q;
        if (wb_en && wb_rd != 5'd0) begin
            rf_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
            rf_q <= '{default: '0};
        end else begin
            ex_q <= ex_d;
            rf_q <= rf_d;
        end
    end

    assign ex_valid       = ex_q.valid;
    assign ex_pc          = ex_q.pc;
    assign ex_rs1_data    = ex_q.rs1_data;
    assign ex_rs2_data    = ex_q.rs2_data;
    assign ex_imm         = ex_q.imm;
    assign ex_rd          = ex_q.rd;
    assign ex_alu_op      = ex_q.alu_op;
    assign ex_alu_src     = ex_q.alu_src;
    assign ex_pc_src      = ex_q.pc_src;
    assign ex_mem_read    = ex_q.mem_read;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_funct3      = ex_q.funct3;
    assign ex_branch_type = ex_q.branch_type;

endmodule

// File: tb/tb_decode.sv
// Directed, table-driven bench for the RV32I decode stage.
module tb_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] fetch_dec_reg;
    logic        flush, wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_pc_src, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_funct3, ex_branch_type;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .fetch_dec_reg(fetch_dec_reg), .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_pc_src(ex_pc_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_funct3(ex_funct3),
        .ex_branch_type(ex_branch_type)
    );

    // ctl bits: {alu_src, pc_src, mem_read, mem_write, reg_write}
    localparam logic [4:0] RW = 5'b00001, MW = 5'b00010, MR = 5'b00100,
                           PC = 5'b01000, AS = 5'b10000;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        flush;
        logic        stall;
        logic        valid;
        logic [31:0] exp_pc;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [4:0]  ctl;
        logic [2:0]  bt;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } vec_t;

    function automatic vec_t v(logic [31:0] inst, logic [31:0] pc, logic we, logic [4:0] wr,
                               logic [31:0] wd, logic fl, logic st, logic vl, logic [4:0] rd,
                               logic [31:0] imm, logic [3:0] alu, logic [4:0] ctl,
                               logic [2:0] bt, logic [2:0] f3, logic [31:0] r1, logic [31:0] r2);
        vec_t t;
        t.inst = inst; t.pc = pc; t.wb_en = we; t.wb_rd = wr; t.wb_data = wd;
        t.flush = fl; t.stall = st; t.valid = vl; t.exp_pc = vl ? pc : 32'h0;
        t.rd = rd; t.imm = imm; t.alu = alu; t.ctl = ctl; t.bt = bt; t.f3 = f3;
        t.rs1 = r1; t.rs2 = r2;
        return t;
    endfunction

    function automatic vec_t bub(logic [31:0] inst, logic [31:0] pc, logic we, logic [4:0] wr,
                                 logic [31:0] wd, logic fl, logic st);
        return v(inst, pc, we, wr, wd, fl, st, 1'b0, 5'd0, 32'h0, 4'd0, 5'd0, 3'd0, 3'd0,
                 32'h0, 32'h0);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ex(string tag, vec_t e);
        chk({tag, " ex_valid"}, {31'h0, ex_valid}, {31'h0, e.valid});
        chk({tag, " ex_pc"}, ex_pc, e.exp_pc);
        chk({tag, " ex_rd"}, {27'h0, ex_rd}, {27'h0, e.rd});
        chk({tag, " ex_imm"}, ex_imm, e.imm);
        chk({tag, " ex_alu_op"}, {28'h0, ex_alu_op}, {28'h0, e.alu});
        chk({tag, " ctl"}, {27'h0, ex_alu_src, ex_pc_src, ex_mem_read, ex_mem_write, ex_reg_write},
            {27'h0, e.ctl});
        chk({tag, " ex_branch_type"}, {29'h0, ex_branch_type}, {29'h0, e.bt});
        chk({tag, " ex_funct3"}, {29'h0, ex_funct3}, {29'h0, e.f3});
        chk({tag, " ex_rs1_data"}, ex_rs1_data, e.rs1);
        chk({tag, " ex_rs2_data"}, ex_rs2_data, e.rs2);
    endtask

    task automatic drive(vec_t e);
        fetch_dec_reg = {e.inst, e.pc};
        wb_en = e.wb_en; wb_rd = e.wb_rd; wb_data = e.wb_data; flush = e.flush;
    endtask

    task automatic apply(string tag, vec_t e);
        @(negedge clk);
        drive(e);
        #1 chk({tag, " stall"}, {31'h0, stall}, {31'h0, e.stall});
        @(posedge clk);
        #1 check_ex(tag, e);
    endtask

    vec_t vecs[21];

    initial begin
        vecs[0]  = v(32'hFE000CE3, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFF8, 0, 0, 1, 0, 0, 0);
        vecs[1]  = v(32'h123450B7, 32'h104, 0, 0, 0, 0, 0, 1, 1, 32'h12345000, 10, AS|RW, 0, 0, 0, 0);
        vecs[2]  = v(32'h00318233, 32'h108, 1, 3, 32'hDEADBEEF, 0, 0, 1, 4, 0, 0, RW, 0, 0,
                     32'hDEADBEEF, 32'hDEADBEEF);
        vecs[3]  = v(32'h403003B3, 32'h10C, 1, 0, 32'h12345678, 0, 0, 1, 7, 0, 1, RW, 0, 0,
                     0, 32'hDEADBEEF);
        vecs[4]  = v(32'h000004B3, 32'h110, 0, 0, 0, 0, 0, 1, 9, 0, 0, RW, 0, 0, 0, 0);
        vecs[5]  = v(32'hFFF18513, 32'h114, 0, 0, 0, 0, 0, 1, 10, 32'hFFFFFFFF, 0, AS|RW, 0, 0,
                     32'hDEADBEEF, 0);
        vecs[6]  = v(32'h4041D593, 32'h118, 0, 0, 0, 0, 0, 1, 11, 32'h00000404, 7, AS|RW, 0, 0,
                     32'hDEADBEEF, 0);
        vecs[7]  = v(32'h008000EF, 32'h11C, 0, 0, 0, 0, 0, 1, 1, 32'h8, 0, AS|PC|RW, 7, 0, 0, 0);
        vecs[8]  = v(32'h00001117, 32'h120, 0, 0, 0, 0, 0, 1, 2, 32'h1000, 0, AS|PC|RW, 0, 0, 0, 0);
        vecs[9]  = v(32'hFE302E23, 32'h124, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFC, 0, AS|MW, 0, 2,
                     0, 32'hDEADBEEF);
        vecs[10] = v(32'h0000A283, 32'h128, 0, 0, 0, 0, 0, 1, 5, 0, 0, AS|MR|RW, 0, 2, 0, 0);
        vecs[11] = bub(32'h00228333, 32'h12C, 0, 0, 0, 0, 1);
        vecs[12] = v(32'h00228333, 32'h12C, 0, 0, 0, 0, 0, 1, 6, 0, 0, RW, 0, 0, 0, 0);
        vecs[13] = v(32'h0000A003, 32'h130, 0, 0, 0, 0, 0, 1, 0, 0, 0, AS|MR|RW, 0, 2, 0, 0);
        vecs[14] = v(32'h00000633, 32'h134, 0, 0, 0, 0, 0, 1, 12, 0, 0, RW, 0, 0, 0, 0);
        vecs[15] = v(32'h0000A283, 32'h138, 0, 0, 0, 0, 0, 1, 5, 0, 0, AS|MR|RW, 0, 2, 0, 0);
        vecs[16] = bub(32'h00228333, 32'h13C, 1, 13, 32'hCAFEF00D, 1, 0);
        vecs[17] = v(32'h00068733, 32'h140, 0, 0, 0, 0, 0, 1, 14, 0, 0, RW, 0, 0, 32'hCAFEF00D, 0);
        vecs[18] = v(32'h00002F83, 32'h144, 0, 0, 0, 0, 0, 1, 31, 0, 0, AS|MR|RW, 0, 2, 0, 0);
        vecs[19] = bub(32'hFFFFFFFF, 32'h148, 0, 0, 0, 0, 0);
        vecs[20] = bub(32'h00000000, 32'h14C, 0, 0, 0, 0, 0);

        // Reset held for two edges with an addi in decode.
        rst = 1'b1;
        drive(bub(32'h00500093, 32'h0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 check_ex("reset", bub(0, 0, 0, 0, 0, 0, 0));
        chk("reset stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apply("release", v(32'h00500093, 32'h0, 0, 0, 0, 0, 0, 1, 1, 32'h5, 0, AS|RW, 0, 0, 0, 0));

        for (int i = 0; i < 21; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset arriving while a load-use stall is pending clears both pipeline and register file.
        apply("ld_pre_rst", v(32'h0000A283, 32'h200, 0, 0, 0, 0, 0, 1, 5, 0, 0, AS|MR|RW, 0, 2, 0, 0));
        @(negedge clk);
        drive(bub(32'h00228333, 32'h204, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #1 chk("mid_stall stall", {31'h0, stall}, 32'h1);
        @(posedge clk);
        #1 chk("post_rst ex_valid", {31'h0, ex_valid}, 32'h0);
        chk("post_rst stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apply("rf_cleared", v(32'h003187B3, 32'h208, 0, 0, 0, 0, 0, 1, 15, 0, 0, RW, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
